// File: rtl/picobello_pkg.sv
// Shared picobello types for the multicast address encoding.
//   mask_sel_t        : {offset, len} selector that locates a coordinate
//                       field inside an address / multicast mask
//   sam_idx_t         : multicast SAM entry index
//   user_mask_t       : multicast mask carried in the AXI user field
//   mcast_user_t      : AXI user payload of a multicast request
//   McastCoordWidth   : default coordinate width
//   mcast_subset_next : next subset of `mask` after `sub`, in ascending order
package picobello_pkg;

  localparam int unsigned McastCoordWidth = 4;
  localparam int unsigned SamIdxWidth     = 4;
  localparam int unsigned UserMaskWidth   = 48;

  typedef struct packed {
    logic [5:0] offset;
    logic [5:0] len;
  } mask_sel_t;

  typedef logic [SamIdxWidth-1:0]   sam_idx_t;
  typedef logic [UserMaskWidth-1:0] user_mask_t;

  typedef struct packed {
    user_mask_t mcast_mask;
  } mcast_user_t;

  // Subtracting the mask and re-masking steps through all subsets of the
  // mask bits in ascending order; the result wraps to 0 after the last one.
  function automatic logic [McastCoordWidth-1:0] mcast_subset_next(
    input logic [McastCoordWidth-1:0] sub,
    input logic [McastCoordWidth-1:0] mask
  );
    return (sub - mask) & mask;
  endfunction

endpackage

// File: rtl/picobello_mcast_field_sel.sv
// Combinational extract/insert of one coordinate field selected by mask_sel_t.
//   ext_addr/ext_mask/ext_sel : word pair and selector to extract from
//   fld_addr/fld_mask         : extracted fields, zero-extended to CoordWidth
//   ins_addr/ins_sel/ins_val  : word, selector and value to insert
//   ins_out                   : ins_addr with the selected field replaced
// The field length saturates at CoordWidth; bits beyond AddrWidth read as 0
// and are never written.
module picobello_mcast_field_sel import picobello_pkg::*; #(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned CoordWidth = 4
) (
  input  logic [AddrWidth-1:0]  ext_addr,
  input  logic [AddrWidth-1:0]  ext_mask,
  input  mask_sel_t             ext_sel,
  output logic [CoordWidth-1:0] fld_addr,
  output logic [CoordWidth-1:0] fld_mask,
  input  logic [AddrWidth-1:0]  ins_addr,
  input  mask_sel_t             ins_sel,
  input  logic [CoordWidth-1:0] ins_val,
  output logic [AddrWidth-1:0]  ins_out
);

  localparam logic [5:0] LenMax = 6'(CoordWidth);

  logic [5:0]           ext_len, ins_len;
  logic [AddrWidth-1:0] ext_fm, ins_fm;

  assign ext_len = (ext_sel.len > LenMax) ? LenMax : ext_sel.len;
  assign ins_len = (ins_sel.len > LenMax) ? LenMax : ins_sel.len;

  // Low-aligned field masks of the effective length.
  assign ext_fm = ~({AddrWidth{1'b1}} << ext_len);
  assign ins_fm = ~({AddrWidth{1'b1}} << ins_len);

  // Right shift past the top of the word fills with zeros.
  assign fld_addr = CoordWidth'((ext_addr >> ext_sel.offset) & ext_fm);
  assign fld_mask = CoordWidth'((ext_mask >> ext_sel.offset) & ext_fm);

  // Left shift drops any part of the field that lands beyond AddrWidth.
  assign ins_out = (ins_addr & ~(ins_fm << ins_sel.offset))
                 | ((AddrWidth'(ins_val) & ins_fm) << ins_sel.offset);

endmodule

// File: rtl/picobello_mcast_dst_iter.sv
// Multicast destination iterator: accepts one multicast request and emits
// one unicast address plus mesh (x,y) ID per output handshake, covering every
// tile selected by the X/Y mask fields (X inner, Y outer, ascending).
//   clk_i, rst_i          : clock, async active-high reset
//   in_valid_i/in_ready_o : request handshake
//   in_addr_i, in_mask_i  : multicast base address and don't-care mask
//   in_mask_x_i/_y_i      : field selectors for X and Y
//   out_valid_o/out_ready_i : destination handshake
//   out_addr_o, out_dst_x_o, out_dst_y_o, out_last_o : destination beat
//   busy_o                : high while iterating
module picobello_mcast_dst_iter import picobello_pkg::*; #(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned CoordWidth = 4,
  parameter int unsigned XIdOffset  = 0,
  parameter int unsigned YIdOffset  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AddrWidth-1:0]  in_addr_i,
  input  logic [AddrWidth-1:0]  in_mask_i,
  input  mask_sel_t             in_mask_x_i,
  input  mask_sel_t             in_mask_y_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [AddrWidth-1:0]  out_addr_o,
  output logic [CoordWidth-1:0] out_dst_x_o,
  output logic [CoordWidth-1:0] out_dst_y_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE, ITER} state_e;

  state_e state_q, state_d;
  logic   accept, step;

  logic [AddrWidth-1:0]  addr_q;
  mask_sel_t             sel_x_q, sel_y_q;
  logic [CoordWidth-1:0] mx_q, my_q, bx_q, by_q, sx_q, sy_q;

  logic [CoordWidth-1:0] ax_d, mx_d, ay_d, my_d;
  logic [CoordWidth-1:0] cur_x, cur_y, sx_nx, sy_nx;
  logic [AddrWidth-1:0]  addr_x;
  logic                  last;

  assign cur_x = bx_q | sx_q;
  assign cur_y = by_q | sy_q;
  assign sx_nx = (sx_q - mx_q) & mx_q;
  assign sy_nx = (sy_q - my_q) & my_q;
  assign last  = (sx_nx == '0) && (sy_nx == '0);

  // X extracts from the incoming request and inserts into the latched one;
  // Y inserts on top of the X result so Y wins where the fields overlap.
  picobello_mcast_field_sel #(.AddrWidth(AddrWidth), .CoordWidth(CoordWidth)) u_sel_x (
    .ext_addr (in_addr_i),
    .ext_mask (in_mask_i),
    .ext_sel  (in_mask_x_i),
    .fld_addr (ax_d),
    .fld_mask (mx_d),
    .ins_addr (addr_q),
    .ins_sel  (sel_x_q),
    .ins_val  (cur_x),
    .ins_out  (addr_x)
  );

  picobello_mcast_field_sel #(.AddrWidth(AddrWidth), .CoordWidth(CoordWidth)) u_sel_y (
    .ext_addr (in_addr_i),
    .ext_mask (in_mask_i),
    .ext_sel  (in_mask_y_i),
    .fld_addr (ay_d),
    .fld_mask (my_d),
    .ins_addr (addr_x),
    .ins_sel  (sel_y_q),
    .ins_val  (cur_y),
    .ins_out  (out_addr_o)
  );

  assign out_dst_x_o = cur_x + CoordWidth'(XIdOffset);
  assign out_dst_y_o = cur_y + CoordWidth'(YIdOffset);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    busy_o      = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
        out_last_o  = last;
        if (out_ready_i) begin
          step = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      sel_x_q <= '0;
      sel_y_q <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else if (accept) begin
      addr_q  <= in_addr_i;
      sel_x_q <= in_mask_x_i;
      sel_y_q <= in_mask_y_i;
      mx_q    <= mx_d;
      my_q    <= my_d;
      bx_q    <= ax_d & ~mx_d;
      by_q    <= ay_d & ~my_d;
      sx_q    <= '0;
      sy_q    <= '0;
    end else if (step) begin
      // X wrapping to 0 carries into Y; on the last beat both land on 0.
      if (sx_nx != '0) begin
        sx_q <= sx_nx;
      end else begin
        sx_q <= '0;
        sy_q <= sy_nx;
      end
    end
  end

endmodule

// File: tb/tb_picobello_mcast_dst_iter.sv
module tb_picobello_mcast_dst_iter;
  import picobello_pkg::*;

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [47:0] a;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [47:0] in_addr = '0, in_mask = '0;
  mask_sel_t   sel_x = '0, sel_y = '0;
  logic        out_ready = 1'b0;
  int          sel_dut = 0;

  logic        r0, ov0, l0, b0, r1, ov1, l1, b1;
  logic [47:0] a0, a1;
  logic [3:0]  x0, y0, x1, y1;

  logic        m_in_ready, m_out_valid, m_last, m_busy;
  logic [47:0] m_addr;
  logic [3:0]  m_x, m_y;

  int n_checks = 0;
  int n_errors = 0;
  beat_t expq[$];

  always #5 clk = ~clk;

  picobello_mcast_dst_iter dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .in_ready_o(r0),
    .in_addr_i(in_addr), .in_mask_i(in_mask), .in_mask_x_i(sel_x), .in_mask_y_i(sel_y),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_addr_o(a0),
    .out_dst_x_o(x0), .out_dst_y_o(y0), .out_last_o(l0), .busy_o(b0)
  );

  picobello_mcast_dst_iter #(.XIdOffset(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_ready_o(r1),
    .in_addr_i(in_addr), .in_mask_i(in_mask), .in_mask_x_i(sel_x), .in_mask_y_i(sel_y),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_addr_o(a1),
    .out_dst_x_o(x1), .out_dst_y_o(y1), .out_last_o(l1), .busy_o(b1)
  );

  always_comb begin
    m_in_ready  = (sel_dut != 0) ? r1  : r0;
    m_out_valid = (sel_dut != 0) ? ov1 : ov0;
    m_last      = (sel_dut != 0) ? l1  : l0;
    m_busy      = (sel_dut != 0) ? b1  : b0;
    m_addr      = (sel_dut != 0) ? a1  : a0;
    m_x         = (sel_dut != 0) ? x1  : x0;
    m_y         = (sel_dut != 0) ? y1  : y0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: field bits by position, destinations by enumerating all
  // coordinate values that agree with the address outside the mask.
  function automatic int eff_len(input mask_sel_t s);
    return (s.len > 6'd4) ? 4 : int'(s.len);
  endfunction

  function automatic logic [3:0] fld(input logic [47:0] w, input mask_sel_t s);
    logic [3:0] r = '0;
    for (int i = 0; i < eff_len(s); i++) begin
      int p = int'(s.offset) + i;
      if (p < 48 && ((w >> p) & 48'd1) != 48'd0) r = r | 4'(1 << i);
    end
    return r;
  endfunction

  function automatic logic [47:0] put(input logic [47:0] w, input mask_sel_t s, input logic [3:0] v);
    logic [47:0] r = w;
    for (int i = 0; i < eff_len(s); i++) begin
      int p = int'(s.offset) + i;
      if (p < 48) begin
        r = r & ~(48'd1 << p);
        if (((v >> i) & 4'd1) != 4'd0) r = r | (48'd1 << p);
      end
    end
    return r;
  endfunction

  task automatic build(input logic [47:0] a, input logic [47:0] m,
                       input mask_sel_t sx, input mask_sel_t sy, input int xoff);
    logic [3:0] ax, mx, ay, my;
    beat_t b;
    ax = fld(a, sx); mx = fld(m, sx);
    ay = fld(a, sy); my = fld(m, sy);
    expq.delete();
    for (int vy = 0; vy < 16; vy++) begin
      if (((vy ^ int'(ay)) & ~int'(my) & 15) != 0) continue;
      for (int vx = 0; vx < 16; vx++) begin
        if (((vx ^ int'(ax)) & ~int'(mx) & 15) != 0) continue;
        b.x    = 4'(vx + xoff);
        b.y    = 4'(vy);
        b.a    = put(put(a, sx, 4'(vx)), sy, 4'(vy));
        b.last = 1'b0;
        expq.push_back(b);
      end
    end
    expq[expq.size()-1].last = 1'b1;
  endtask

  // One request on the selected DUT; rst_at >= 0 asserts reset while the
  // beat with that index is on the output.
  task automatic run_req(input int which, input logic [47:0] a, input logic [47:0] m,
                         input mask_sel_t sx, input mask_sel_t sy,
                         input bit rnd, input int rst_at);
    beat_t b;
    int    hs = 0, cyc = 0;
    build(a, m, sx, sy, which);
    @(negedge clk);
    sel_dut = which;
    in_addr = a; in_mask = m; sel_x = sx; sel_y = sy;
    out_ready = 1'b0;
    chk("in_ready_idle", 64'(m_in_ready), 64'd1);
    if (which != 0) v1 = 1'b1; else v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    while (expq.size() > 0 && cyc < 2000) begin
      if (hs == rst_at) begin
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_in_ready", 64'(m_in_ready), 64'd1);
        chk("rst_busy", 64'(m_busy), 64'd0);
        rst = 1'b0;
        expq.delete();
        return;
      end
      chk("out_valid", 64'(m_out_valid), 64'd1);
      if (!m_out_valid) break;
      chk("in_ready_busy", 64'(m_in_ready), 64'd0);
      chk("busy", 64'(m_busy), 64'd1);
      b = expq[0];
      chk("dst_x", 64'(m_x), 64'(b.x));
      chk("dst_y", 64'(m_y), 64'(b.y));
      chk("addr", 64'(m_addr), 64'(b.a));
      chk("last", 64'(m_last), 64'(b.last));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        void'(expq.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats_left", 64'(expq.size()), 64'd0);
    out_ready = 1'b0;
    chk("done_out_valid", 64'(m_out_valid), 64'd0);
    chk("done_in_ready", 64'(m_in_ready), 64'd1);
    chk("done_busy", 64'(m_busy), 64'd0);
  endtask

  initial begin
    mask_sel_t cx, cy;
    cx = {6'd20, 6'd2};
    cy = {6'd18, 6'd2};

    @(negedge clk);
    chk("rst_in_ready0", 64'(r0), 64'd1);
    chk("rst_out_valid0", 64'(ov0), 64'd0);
    chk("rst_last0", 64'(l0), 64'd0);
    chk("rst_busy0", 64'(b0), 64'd0);
    chk("rst_addr0", 64'(a0), 64'd0);
    chk("rst_x0", 64'(x0), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_req(0, 48'h0010_0000, 48'h0, cx, cy, 1'b0, -1);
    run_req(0, 48'h0010_0000, 48'h0030_0000, cx, cy, 1'b0, -1);
    run_req(0, 48'h0014_0000, 48'h0028_0000, cx, cy, 1'b0, -1);
    run_req(0, 48'h0014_0000, 48'h003C_0000, cx, cy, 1'b1, -1);
    run_req(0, 48'h0010_0000, 48'h0030_0000, cx, cy, 1'b0, 1);
    run_req(0, 48'h0010_0000, 48'h0030_0000, cx, cy, 1'b0, -1);
    run_req(1, 48'h0, 48'h100, {6'd4, 6'd0}, {6'd8, 6'd1}, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      logic [47:0] ra, rm;
      mask_sel_t   rx, ry;
      ra = {16'($urandom), $urandom};
      rm = {16'($urandom), $urandom} & {16'($urandom), $urandom} & {16'($urandom), $urandom};
      rx = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 7))};
      ry = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 7))};
      run_req(int'($urandom_range(0, 1)), ra, rm, rx, ry, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
